score_bcd: RTL and testbench
============================

# score_bcd

Display-side stage downstream of the 16-bit score register: watches the registered score value, converts it to packed BCD with a sequential shift-and-add-3 (double-dabble) engine, and presents stable digit nibbles plus a leading-zero blanking mask to the HUD/hex-display driver. The outputs change only on completed conversions, so the display never shows a partially converted value. One conversion costs WIDTH+2 cycles, which is negligible against the frame-rate score updates.

## Interface
- WIDTH, 16, binary score width.
- DIGITS, 5, BCD digit count. Legal only when 10^DIGITS > 2^WIDTH - 1.
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  reset, asynchronous, active-low.
- score  input  WIDTH  binary score from the score register; unsigned; may change on any cycle.
- bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0]. Registered.
- blank  output  DIGITS  1 = digit is a leading zero to be blanked. Registered.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse in the cycle after bcd/blank update.

## Operation
- Internal state:
  - last_score: WIDTH bits, the value last accepted for conversion.
  - shift register: WIDTH binary bits plus 4*DIGITS BCD bits.
  - bit counter: 0..WIDTH-1.
  - FSM states: IDLE, SHIFT, LOAD.
- IDLE, on an edge where score != last_score:
  - load the binary part of the shift register with score and clear the BCD part;
  - set last_score <= score, counter <= 0;
  - go to SHIFT.
- IDLE otherwise: hold.
- SHIFT, on each edge:
  - every BCD nibble >= 5 gets +3 (all nibbles in parallel, combinational);
  - the whole register shifts left by 1, the binary MSB entering the BCD LSB;
  - counter increments.
  - The edge on which counter == WIDTH-1 performs the final shift and goes to LOAD.
- LOAD, on one edge:
  - bcd <= BCD part;
  - blank[i] <= 1 when digit i and all higher digits are 0, for i >= 1;
  - blank[0] is always 0;
  - done <= 1; go to IDLE.
- done is 0 in every other cycle.
- busy = (state != IDLE), registered with the state.
- Score changes during SHIFT/LOAD are ignored by the engine. On return to IDLE, the compare against last_score picks up the latest value, so the display always converges to the current score.
- Reset (asynchronous, any state, including mid-conversion):
  - state = IDLE, last_score = 0, shift register = 0, counter = 0;
  - bcd = 0, blank = {DIGITS-1 ones, 0} (shows a single "0"), busy = 0, done = 0.
- Score 0 after reset triggers no conversion; the reset outputs are already correct.
- Maximum value 2^WIDTH-1 = 65535 gives digits 6,5,5,3,5. No overflow is possible with legal parameters.

## Timing
- Edge E0: the IDLE compare sees the new score and the value is captured.
- Edges E1..E16 (WIDTH edges): shifts.
- Edge E17: bcd/blank update, done rises.
- done is high for the cycle between E17 and E18.
- busy is high from after E0 until after E17.
- Input-to-output latency: WIDTH+1 edges after capture.
- A new capture can occur at E18 at the earliest.
- Back-to-back score increments every cycle result in conversions of sampled values, one every WIDTH+2 cycles. Intermediate values may be skipped; the final value is always displayed.
- Reset deassertion: first possible capture is on the first edge after Reset_n rises.

## Test plan
- Reset with score=0, run 50 cycles: bcd=0x00000, blank=5'b11110, busy=0, done never pulses.
- score 0->1 at E0: busy high E0+ to E17+; bcd=0x00001 and done=1 exactly after E17; blank=5'b11110.
- score=65535: bcd=0x65535, blank=5'b00000, after 17 edges.
- score=1234 then 100:
  - first result bcd=0x01234, blank=5'b10000;
  - second result bcd=0x00100, blank=5'b11000;
  - each result is followed by exactly one done pulse.
- score 10 -> 20 changed 5 cycles into the conversion:
  - first result 0x00010;
  - second capture at the edge after done;
  - final bcd=0x00020;
  - bcd is never 0x00020 before the second done.
- Reset_n asserted mid-SHIFT with score=999:
  - outputs immediately reset values, busy=0;
  - after release, conversion restarts and yields 0x00999, blank=5'b11000.

Source files
------------

// File: rtl/score_bcd.sv
// Display-side score converter: turns the registered binary score into packed BCD
// with a sequential double-dabble engine, updating digits and blanking mask atomically.
module score_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [WIDTH-1:0]      score,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic                  done
);

    localparam int BW  = 4 * DIGITS;
    localparam int SRW = WIDTH + BW;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t            state;
    logic [WIDTH-1:0]  last_score;
    logic [SRW-1:0]    shift_reg;
    logic [SRW-1:0]    adjusted;
    logic [CW-1:0]     bit_cnt;
    logic [DIGITS-1:0] blank_next;
    logic              higher_zero;

    // Binary part sits in the low WIDTH bits, BCD digits above it; every nibble >= 5 gets +3
    always_comb begin
        adjusted = shift_reg;
        for (int i = 0; i < DIGITS; i++) begin
            if (shift_reg[WIDTH+4*i +: 4] >= 4'd5)
                adjusted[WIDTH+4*i +: 4] = shift_reg[WIDTH+4*i +: 4] + 4'd3;
        end
    end

    // A digit blanks only if it and every digit above it are zero; the ones digit always shows
    always_comb begin
        blank_next  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero & (shift_reg[WIDTH+4*i +: 4] == 4'd0);
            blank_next[i] = higher_zero;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            last_score <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            bcd        <= '0;
            blank      <= BLANK_RST;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (score != last_score) begin
                        shift_reg  <= {{BW{1'b0}}, score};
                        last_score <= score;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= {adjusted[SRW-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT)
                        state <= LOAD;
                end
                LOAD: begin
                    bcd   <= shift_reg[SRW-1:WIDTH];
                    blank <= blank_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd.sv
// Bench for score_bcd: table-driven conversions checked through a scoreboard,
// plus hand-written sequences for timing, mid-conversion changes and reset.
module tb_score_bcd;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] score;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] score;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  blank;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[8];
    int   checks    = 0;
    int   errors    = 0;
    int   doneCount = 0;
    int   pushCount = 0;

    score_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .score  (score),
        .bcd    (bcd),
        .blank  (blank),
        .busy   (busy),
        .done   (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a new score on a falling edge and record the result it should produce
    task automatic applyStimulus(input logic [15:0] v, input logic [19:0] eBcd, input logic [4:0] eBlank);
        exp_t e;
        @(negedge Clk);
        score   = v;
        e.bcd   = eBcd;
        e.blank = eBlank;
        expQ.push_back(e);
        pushCount++;
    endtask

    task automatic waitDone(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge Clk);
            cycles++;
        end while (done !== 1'b1 && cycles < limit);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", limit);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            doneCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done with bcd 0x%0h, expected no done", bcd);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_bcd", 32'(bcd), 32'(e.bcd));
                checkOutput("sb_blank", 32'(blank), 32'(e.blank));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int busyHigh;
        int dn;
        int firstDone;
        int gap;
        logic busyAfter;
        logic earlySeen;

        vecs[0] = '{16'd65535, 20'h65535, 5'b00000};
        vecs[1] = '{16'd1234,  20'h01234, 5'b10000};
        vecs[2] = '{16'd100,   20'h00100, 5'b11000};
        vecs[3] = '{16'd9,     20'h00009, 5'b11110};
        vecs[4] = '{16'd12345, 20'h12345, 5'b00000};
        vecs[5] = '{16'd50000, 20'h50000, 5'b00000};
        vecs[6] = '{16'd9999,  20'h09999, 5'b10000};
        vecs[7] = '{16'd10,    20'h00010, 5'b11100};

        Reset_n = 1'b0;
        score   = 16'd0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;

        // Idle after reset with score 0: nothing should convert
        busyHigh = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (busy !== 1'b0) busyHigh++;
        end
        checkOutput("reset_bcd", 32'(bcd), 32'h00000);
        checkOutput("reset_blank", 32'(blank), 32'b11110);
        checkOutput("reset_busy_cycles", 32'(busyHigh), 32'd0);
        checkOutput("reset_done_count", 32'(doneCount), 32'd0);

        // Cycle-exact timing of a 0 -> 1 conversion
        applyStimulus(16'd1, 20'h00001, 5'b11110);
        busyHigh = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge Clk);
            if (busy === 1'b1 && done === 1'b0) busyHigh++;
        end
        checkOutput("t1_busy_window", 32'(busyHigh), 32'd17);
        @(negedge Clk);
        checkOutput("t1_done_e17", 32'(done), 32'd1);
        checkOutput("t1_busy_e17", 32'(busy), 32'd0);
        checkOutput("t1_bcd_e17", 32'(bcd), 32'h00001);
        @(negedge Clk);
        checkOutput("t1_done_e18", 32'(done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].score, vecs[i].bcd, vecs[i].blank);
            waitDone(40, cyc);
            checkOutput($sformatf("vec%0d_latency", i), 32'(cyc), 32'd18);
            @(negedge Clk);
            checkOutput($sformatf("vec%0d_single_done", i), 32'(done), 32'd0);
        end

        // Score 10 changes to 20 five cycles into the conversion
        applyStimulus(16'd11, 20'h00011, 5'b11100);
        waitDone(40, cyc);
        applyStimulus(16'd10, 20'h00010, 5'b11100);
        repeat (5) @(negedge Clk);
        score = 16'd20;
        expQ.push_back('{20'h00020, 5'b11100});
        pushCount++;
        dn = 0; cyc = 0; firstDone = 0; earlySeen = 1'b0; busyAfter = 1'b0;
        while (dn < 2 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (dn == 1 && cyc == firstDone + 1) busyAfter = busy;
            if (done === 1'b1) begin
                dn++;
                if (dn == 1) firstDone = cyc;
            end
            if (dn < 2 && bcd === 20'h00020) earlySeen = 1'b1;
        end
        gap = cyc - firstDone;
        checkOutput("chg_done_count", 32'(dn), 32'd2);
        checkOutput("chg_recapture_busy", 32'(busyAfter), 32'd1);
        checkOutput("chg_gap", 32'(gap), 32'd18);
        checkOutput("chg_early_20", 32'(earlySeen), 32'd0);
        checkOutput("chg_final_bcd", 32'(bcd), 32'h00020);

        // Reset asserted mid-shift, then the conversion restarts from scratch
        applyStimulus(16'd999, 20'h00999, 5'b11000);
        repeat (6) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_bcd", 32'(bcd), 32'h00000);
        checkOutput("rst_mid_blank", 32'(blank), 32'b11110);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_done", 32'(done), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        waitDone(40, cyc);
        checkOutput("rst_restart_latency", 32'(cyc), 32'd18);
        checkOutput("rst_restart_bcd", 32'(bcd), 32'h00999);
        repeat (25) @(negedge Clk);

        checkOutput("sb_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("sb_done_total", 32'(doneCount), 32'(pushCount));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
